// File: rtl/me_pkg.sv
// Shared motion-estimation definitions: SAE result width, default search size and
// the min-select state encoding, used by both the SAE processor and sae_min_select.
package me_pkg;

    localparam int SAE_WIDTH            = 10;
    localparam int DEFAULT_SEARCH_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } me_state_e;

    // A search of width 1 still needs a 1-bit coordinate to keep ports legal.
    function automatic int coord_width(input int search_width);
        return (search_width > 1) ? $clog2(search_width) : 1;
    endfunction

endpackage

// File: rtl/sae_min_select_if.sv
// Candidate stream and result bus of sae_min_select; master drives candidates,
// slave is the min-select block.
interface sae_min_select_if #(
    parameter int SEARCH_WIDTH = me_pkg::DEFAULT_SEARCH_WIDTH,
    parameter int SAE_WIDTH    = me_pkg::SAE_WIDTH
);
    localparam int CW = me_pkg::coord_width(SEARCH_WIDTH);

    logic                 i_start;
    logic                 i_sae_valid;
    logic [SAE_WIDTH-1:0] i_sae_result;
    logic                 o_sae_ready;
    logic [SAE_WIDTH-1:0] o_best_sae;
    logic [CW-1:0]        o_best_x;
    logic [CW-1:0]        o_best_y;
    logic                 o_done;

    modport master (
        output i_start, i_sae_valid, i_sae_result,
        input  o_sae_ready, o_best_sae, o_best_x, o_best_y, o_done
    );

    modport slave (
        input  i_start, i_sae_valid, i_sae_result,
        output o_sae_ready, o_best_sae, o_best_x, o_best_y, o_done
    );

endinterface

// File: rtl/mv_counter.sv
// Raster (x fastest) position counter over a SEARCH_WIDTH x SEARCH_WIDTH grid,
// with synchronous clear, advance enable and a last-position flag.
module mv_counter
    import me_pkg::*;
#(
    parameter int SEARCH_WIDTH = DEFAULT_SEARCH_WIDTH,
    localparam int CW          = coord_width(SEARCH_WIDTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_last
);

    localparam logic [CW-1:0] LAST_POS = CW'(SEARCH_WIDTH - 1);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_enable) begin
            if (x_q == LAST_POS) begin
                x_d = '0;
                y_d = (y_q == LAST_POS) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign o_x    = x_q;
    assign o_y    = y_q;
    assign o_last = (x_q == LAST_POS) && (y_q == LAST_POS);

endmodule

// File: rtl/sae_min_select.sv
// Selects the minimum SAE (first occurrence wins ties) over one candidate search.
// Optional macro SAE_EARLY_EXIT_EN: an accepted SAE of 0 ends the search at once.
module sae_min_select #(
    parameter int SEARCH_WIDTH = me_pkg::DEFAULT_SEARCH_WIDTH,
    parameter int SAE_WIDTH    = me_pkg::SAE_WIDTH
) (
    input  logic            i_clk,
    input  logic            i_rst,
    sae_min_select_if.slave bus
);
    import me_pkg::*;

    localparam int CW = coord_width(SEARCH_WIDTH);

    me_state_e            state_q;
    logic [SAE_WIDTH-1:0] min_q, min_d;
    logic [CW-1:0]        min_x_q, min_x_d;
    logic [CW-1:0]        min_y_q, min_y_d;
    logic [SAE_WIDTH-1:0] best_sae_q;
    logic [CW-1:0]        best_x_q;
    logic [CW-1:0]        best_y_q;
    logic                 ready_q;
    logic                 done_q;

    logic [CW-1:0]        cnt_x;
    logic [CW-1:0]        cnt_y;
    logic                 cnt_last;
    logic                 accept;
    logic                 finish;

    // ready_q is high exactly while in COLLECT, so it doubles as the state qualifier.
    assign accept = bus.i_sae_valid && ready_q;

    mv_counter #(
        .SEARCH_WIDTH (SEARCH_WIDTH)
    ) u_mv_counter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (bus.i_start),
        .i_enable (accept && !bus.i_start),
        .o_x      (cnt_x),
        .o_y      (cnt_y),
        .o_last   (cnt_last)
    );

    always_comb begin
        min_d   = min_q;
        min_x_d = min_x_q;
        min_y_d = min_y_q;
        if (accept && (bus.i_sae_result < min_q)) begin
            min_d   = bus.i_sae_result;
            min_x_d = cnt_x;
            min_y_d = cnt_y;
        end
`ifdef SAE_EARLY_EXIT_EN
        finish = accept && (cnt_last || (bus.i_sae_result == '0));
`else
        finish = accept && cnt_last;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            min_q      <= '1;
            min_x_q    <= '0;
            min_y_q    <= '0;
            best_sae_q <= '1;
            best_x_q   <= '0;
            best_y_q   <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A start from any state (including an abandoned COLLECT or the DONE cycle) restarts at (0,0).
            if (bus.i_start) begin
                state_q <= COLLECT;
                min_q   <= '1;
                min_x_q <= '0;
                min_y_q <= '0;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: ;
                    COLLECT: begin
                        min_q   <= min_d;
                        min_x_q <= min_x_d;
                        min_y_q <= min_y_d;
                        if (finish) begin
                            state_q    <= DONE;
                            ready_q    <= 1'b0;
                            done_q     <= 1'b1;
                            best_sae_q <= min_d;
                            best_x_q   <= min_x_d;
                            best_y_q   <= min_y_d;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_sae_ready = ready_q;
    assign bus.o_best_sae  = best_sae_q;
    assign bus.o_best_x    = best_x_q;
    assign bus.o_best_y    = best_y_q;
    assign bus.o_done      = done_q;

endmodule

// File: tb/tb_sae_min_select.sv
// Directed bench for sae_min_select: a table of single-search vectors plus
// hand-written restart, reset-abort and start-in-DONE sequences.
module tb_sae_min_select;

    localparam int SW   = 4;
    localparam int SAEW = 10;
    localparam int NCAND = SW * SW;

    typedef struct {
        string name;
        int    bg;
        int    v1;
        int    i1;
        int    v2;
        int    i2;
        bit    gap;
        int    exp_sae;
        int    exp_x;
        int    exp_y;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    sae_min_select_if #(.SEARCH_WIDTH(SW), .SAE_WIDTH(SAEW)) bus ();

    sae_min_select #(
        .SEARCH_WIDTH (SW),
        .SAE_WIDTH    (SAEW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int prev_sae = 1023;
    int prev_x   = 0;
    int prev_y   = 0;
    vec_t vecs[7];

    always @(negedge clk) if (bus.o_done === 1'b1) done_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t, required below 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic feed(input int value, inout int ready_bad);
        if (bus.o_sae_ready !== 1'b1) ready_bad++;
        bus.i_sae_valid  = 1'b1;
        bus.i_sae_result = SAEW'(value);
        tick();
        bus.i_sae_valid  = 1'b0;
        bus.i_sae_result = '0;
    endtask

    task automatic check_best(input string tag, input int e_sae, input int e_x, input int e_y);
        check({tag, ".best_sae"}, int'(bus.o_best_sae), e_sae);
        check({tag, ".best_x"},   int'(bus.o_best_x),   e_x);
        check({tag, ".best_y"},   int'(bus.o_best_y),   e_y);
    endtask

    function automatic int vec_val(input vec_t v, input int idx);
        if (idx == v.i1) return v.v1;
        if (idx == v.i2) return v.v2;
        return v.bg;
    endfunction

    task automatic run_vec(input vec_t v);
        int n_feed;
        int ready_bad;
        int done0;
        n_feed    = NCAND;
        ready_bad = 0;
`ifdef SAE_EARLY_EXIT_EN
        for (int i = 0; i < NCAND; i++) begin
            if (vec_val(v, i) == 0) begin
                n_feed = i + 1;
                break;
            end
        end
`endif
        done0 = done_cnt;
        pulse_start();
        check_best({v.name, ".hold"}, prev_sae, prev_x, prev_y);
        for (int i = 0; i < n_feed; i++) begin
            if (v.gap && i > 0) tick();
            feed(vec_val(v, i), ready_bad);
        end
        check({v.name, ".ready_in_collect"}, ready_bad, 0);
        check({v.name, ".no_early_done"}, done_cnt - done0, 0);
        check({v.name, ".done_after_last"}, int'(bus.o_done), 1);
        check_best(v.name, v.exp_sae, v.exp_x, v.exp_y);
        tick();
        check({v.name, ".done_one_cycle"}, int'(bus.o_done), 0);
        check({v.name, ".ready_idle"}, int'(bus.o_sae_ready), 0);
        check({v.name, ".done_count"}, done_cnt - done0, 1);
        prev_sae = v.exp_sae;
        prev_x   = v.exp_x;
        prev_y   = v.exp_y;
    endtask

    initial begin
        int ready_bad;
        int done0;

        vecs[0] = '{"single_min",     100,  7,  9, 0,  -1, 1'b0,    7, 1, 2};
        vecs[1] = '{"tie_first",       50,  5,  3, 5,  12, 1'b0,    5, 3, 0};
        vecs[2] = '{"valid_gap",      100,  7,  9, 0,  -1, 1'b1,    7, 1, 2};
        vecs[3] = '{"last_cand",      200,  3, 15, 0,  -1, 1'b0,    3, 3, 3};
        vecs[4] = '{"first_cand_tie", 300,  1,  0, 1,   5, 1'b0,    1, 0, 0};
        vecs[5] = '{"zero_sae",       100,  0,  4, 0,  -1, 1'b0,    0, 0, 1};
        vecs[6] = '{"all_ones_bg",   1023, 1022, 6, 0, -1, 1'b0, 1022, 2, 1};

        rst              = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_sae_valid  = 1'b0;
        bus.i_sae_result = '0;
        ready_bad        = 0;

        // Reset, then idle with a stray valid that must be ignored.
        tick(); tick(); tick();
        rst = 1'b0;
        bus.i_sae_valid = 1'b1;
        tick(); tick(); tick();
        bus.i_sae_valid = 1'b0;
        check_best("reset", 1023, 0, 0);
        check("reset.ready", int'(bus.o_sae_ready), 0);
        check("reset.done", int'(bus.o_done), 0);
        check("reset.done_count", done_cnt, 0);

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Restart after 6 accepts; the start-cycle candidate is ignored.
        done0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 6; i++) feed(1, ready_bad);
        bus.i_start      = 1'b1;
        bus.i_sae_valid  = 1'b1;
        bus.i_sae_result = '0;
        tick();
        bus.i_start      = 1'b0;
        bus.i_sae_valid  = 1'b0;
        check("restart.no_done", done_cnt - done0, 0);
        check_best("restart.hold", prev_sae, prev_x, prev_y);
        for (int i = 0; i < NCAND; i++) feed((i == 0) ? 20 : 90, ready_bad);
        check("restart.done", int'(bus.o_done), 1);
        check_best("restart", 20, 0, 0);
        tick();
        check("restart.single_done", done_cnt - done0, 1);
        check("restart.ready_in_collect", ready_bad, 0);

        // Reset at candidate 8 discards the search; reset wins over a coincident start.
        done0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 8; i++) feed(3, ready_bad);
        check_best("rst_abort.hold", 20, 0, 0);
        rst              = 1'b1;
        bus.i_start      = 1'b1;
        bus.i_sae_valid  = 1'b1;
        tick();
        rst              = 1'b0;
        bus.i_start      = 1'b0;
        check_best("rst_abort", 1023, 0, 0);
        check("rst_abort.ready", int'(bus.o_sae_ready), 0);
        tick(); tick();
        bus.i_sae_valid  = 1'b0;
        check("rst_abort.ready_idle", int'(bus.o_sae_ready), 0);
        check("rst_abort.no_done", done_cnt - done0, 0);

        // Start during DONE: done still pulses once, next cycle is COLLECT.
        done0 = done_cnt;
        pulse_start();
        for (int i = 0; i < NCAND; i++) feed((i == 7) ? 2 : 40, ready_bad);
        check("done_start.done", int'(bus.o_done), 1);
        check_best("done_start.first", 2, 3, 1);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("done_start.ready", int'(bus.o_sae_ready), 1);
        check("done_start.done_count", done_cnt - done0, 1);
        for (int i = 0; i < NCAND; i++) feed((i == 15) ? 9 : 60, ready_bad);
        check("done_start.done2", int'(bus.o_done), 1);
        check_best("done_start.second", 9, 3, 3);
        tick();
        check("done_start.done_count2", done_cnt - done0, 2);
        check("done_start.ready_in_collect", ready_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
